// File: rtl/mem_pkg.sv
// Shared definitions for the multi-beat SRAM controller: access sizes, FSM states
// and the byte-lane mask/alignment helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Misaligned halves/words are forced onto their natural boundary.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE:          align_off = off;
      SZ_HALF:          align_off = {off[1], 1'b0};
      SZ_WORD, 2'b11:   align_off = 2'b00;
      default:          align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: byte_mask = 4'b0001 << off;
      SZ_HALF: byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational lane steering: replicates store data onto every lane position and
// extracts/extends narrow load results from the assembled 32-bit read buffer.
module sram_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_load_signed,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_buf,
  output logic [3:0]  o_mask,
  output logic [31:0] o_store_repl,
  output logic [31:0] o_load_val
);

  logic [1:0]  w_aoff;
  logic [31:0] w_shifted;

  assign w_aoff    = align_off(i_size, i_off);
  assign o_mask    = byte_mask(i_size, i_off);
  assign w_shifted = i_load_buf >> {w_aoff, 3'b000};

  always_comb begin
    o_store_repl = i_store_data;
    case (i_size)
      SZ_BYTE: o_store_repl = {4{i_store_data[7:0]}};
      SZ_HALF: o_store_repl = {2{i_store_data[15:0]}};
      default: o_store_repl = i_store_data;
    endcase
  end

  always_comb begin
    o_load_val = w_shifted;
    case (i_size)
      SZ_BYTE: o_load_val = {{24{i_load_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load_val = {{16{i_load_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_val = w_shifted;
    endcase
  end

endmodule

// File: rtl/sram_ctrl_multibeat.sv
// MEM-stage SRAM controller: splits one 32-bit CPU access into narrow SRAM beats with
// programmable wait states; ready low freezes the pipeline until the access completes.
module sram_ctrl_multibeat
  import mem_pkg::*;
#(
  parameter int DQ_W        = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic                rdEn,
  input  logic [1:0]          size,
  input  logic                loadSigned,
  input  logic [31:0]         address,
  input  logic [31:0]         writeData,
  output logic [31:0]         readData,
  output logic                ready,
  inout  wire  [DQ_W-1:0]     SRAM_DQ,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic [DQ_W/8-1:0]   SRAM_BE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int BEATS  = 32 / DQ_W;
  localparam int LANES  = DQ_W / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t              r_state, w_next_state;
  logic [BEAT_W-1:0]   r_beat, w_cur_beat, w_first_beat, w_nxt_beat;
  logic [2:0]          r_wait, w_wait;
  logic                w_req, w_active, w_last_cyc, w_has_next, w_is_read, w_drive;
  logic [31:0]         w_off, r_buf, w_buf_merged, w_store_repl, w_load_val;
  logic [3:0]          w_mask;
  logic [LANES-1:0]    w_beat_mask;
  logic [DQ_W-1:0]     w_wdata_beat;
  logic [ADDR_W-1:0]   w_word;
  logic                w_unused;

  assign w_off     = address - 32'(ADDR_BASE);
  assign w_word    = w_off[ADDR_W+1:2];
  assign w_unused  = ^w_off[31:ADDR_W+2];
  assign w_req     = rdEn | wrEn;
  assign w_is_read = rdEn & ~wrEn;

  // The request cycle in IDLE already acts as wait cycle 0 of the first active beat.
  assign w_active   = (r_state == ST_BEAT) || ((r_state == ST_IDLE) && w_req);
  assign w_wait     = (r_state == ST_IDLE) ? 3'd0 : r_wait;
  assign w_last_cyc = (w_wait == 3'(WAIT_CYCLES));

  sram_lane_align u_align (
    .i_size        (size),
    .i_off         (w_off[1:0]),
    .i_load_signed (loadSigned),
    .i_store_data  (writeData),
    .i_load_buf    (w_buf_merged),
    .o_mask        (w_mask),
    .o_store_repl  (w_store_repl),
    .o_load_val    (w_load_val)
  );

  // Beats whose lane mask is empty are never visited.
  always_comb begin
    w_first_beat = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (|w_mask[b*LANES +: LANES]) w_first_beat = BEAT_W'(b);
    end
    w_cur_beat = (r_state == ST_IDLE) ? w_first_beat : r_beat;
    w_has_next = 1'b0;
    w_nxt_beat = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if ((b > int'(w_cur_beat)) && (|w_mask[b*LANES +: LANES])) begin
        w_has_next = 1'b1;
        w_nxt_beat = BEAT_W'(b);
      end
    end
    w_beat_mask  = '0;
    w_wdata_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (BEAT_W'(b) == w_cur_beat) begin
        w_beat_mask  = w_mask[b*LANES +: LANES];
        w_wdata_beat = w_store_repl[b*DQ_W +: DQ_W];
      end
    end
  end

  always_comb begin
    w_buf_merged = r_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (BEAT_W'(b) == w_cur_beat) w_buf_merged[b*DQ_W +: DQ_W] = SRAM_DQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_BEAT: begin
        if (w_active) begin
          if (w_last_cyc && !w_has_next) w_next_state = ST_DONE;
          else                           w_next_state = ST_BEAT;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_BE_N = '1;
    w_drive   = 1'b0;
    if (w_active) begin
      SRAM_CE_N = 1'b0;
      SRAM_BE_N = ~w_beat_mask;
      if (wrEn) begin
        w_drive   = 1'b1;
        // With wait states the final beat cycle releases WE_N to hold address/data.
        SRAM_WE_N = (WAIT_CYCLES != 0) && w_last_cyc;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_ADDR = w_word * ADDR_W'(BEATS) + ADDR_W'(w_cur_beat);
  assign SRAM_DQ   = w_drive ? w_wdata_beat : {DQ_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat   <= '0;
      r_wait   <= '0;
      r_buf    <= '0;
      readData <= '0;
    end else if (w_active) begin
      if (w_last_cyc) begin
        r_wait <= '0;
        r_beat <= w_nxt_beat;
      end else begin
        r_wait <= w_wait + 3'd1;
        r_beat <= w_cur_beat;
      end
      if (w_last_cyc && w_is_read) r_buf <= w_buf_merged;
      if (w_last_cyc && !w_has_next && rdEn) readData <= wrEn ? 32'h0 : w_load_val;
    end else begin
      r_wait <= '0;
      r_beat <= '0;
    end
  end

endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// Bench for sram_ctrl_multibeat (DQ_W=16, WAIT_CYCLES=1, ADDR_BASE=1024) with a
// behavioural SRAM and a byte-addressed CPU-view reference memory.
module tb_sram_ctrl_multibeat;

  logic        clk;
  logic        rst, wrEn, rdEn, loadSigned;
  logic [1:0]  size;
  logic [31:0] address, writeData, readData;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic [1:0]  be_n;
  logic        we_n, ce_n, oe_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram    [0:255];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] ref_last;

  int          mon_lo, mon_oe_lo, mon_we_lo;
  logic [17:0] mon_addr0;
  logic [1:0]  mon_ben0;
  logic [31:0] mon_rdata;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_lo;
    int          exp_oe;
    int          exp_we;
    logic [17:0] exp_a0;
    logic [1:0]  exp_be0;
  } vec_t;
  vec_t vt [16];

  sram_ctrl_multibeat #(
    .DQ_W(16), .ADDR_W(18), .WAIT_CYCLES(1), .ADDR_BASE(1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrEn       (wrEn),
    .rdEn       (rdEn),
    .size       (size),
    .loadSigned (loadSigned),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_BE_N  (be_n),
    .SRAM_WE_N  (we_n),
    .SRAM_CE_N  (ce_n),
    .SRAM_OE_N  (oe_n)
  );

  // Clock and SRAM device model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!be_n[0]) sram[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!be_n[1]) sram[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Driver: present one request, watch strobes each cycle until ready returns.
  task automatic do_access(input logic wr, input logic rd, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] dat);
    bit done;
    @(posedge clk); #1;
    wrEn = wr; rdEn = rd; size = sz; loadSigned = sgn; address = addr; writeData = dat;
    mon_lo = 0; mon_oe_lo = 0; mon_we_lo = 0; done = 1'b0;
    mon_addr0 = '0; mon_ben0 = '0; mon_rdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mon_addr0 = sram_addr;
        mon_ben0  = be_n;
      end
      if (!oe_n) mon_oe_lo++;
      if (!we_n) mon_we_lo++;
      if (ready) begin
        done      = 1'b1;
        mon_rdata = readData;
      end else begin
        mon_lo++;
      end
    end
    wrEn = 1'b0; rdEn = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout actual=no_ready expected=ready addr=%h", addr);
    end
  endtask

  // Reference model: byte-addressed memory seen from the CPU side.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input int off, input logic sgn);
    int          n, a;
    logic [31:0] v, m;
    n = nbytes(sz);
    a = off - (off % n);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8 * i));
    if (n < 4) begin
      m = (32'd1 << (8 * n)) - 32'd1;
      if (sgn && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int off, input logic [31:0] d);
    int n, a;
    n = nbytes(sz);
    a = off - (off % n);
    for (int i = 0; i < n; i++) ref_mem[a+i] = d[8*i +: 8];
  endtask

  initial begin
    logic [31:0] d, exp_rd;
    logic [1:0]  sz;
    logic        sgn;
    int          op, off;

    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; size = 2'b00; loadSigned = 1'b0;
    address = '0; writeData = '0; ref_last = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    chk("reset_be_n", 32'(be_n), 32'h3);
    chk("reset_readdata", readData, 32'h0);

    vt[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 4, 0, 2, 18'h0,     2'b00};
    vt[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 4, 4, 0, 18'h0,     2'b00};
    vt[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd1027, 32'h00000055, 32'hDEADBEEF, 2, 0, 1, 18'h1,     2'b01};
    vt[3]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h0,        32'h55ADBEEF, 4, 4, 0, 18'h0,     2'b00};
    vt[4]  = '{1'b0, 1'b1, 2'b00, 1'b1, 32'd1025, 32'h0,        32'hFFFFFFBE, 2, 2, 0, 18'h0,     2'b01};
    vt[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'd1025, 32'h0,        32'h000000BE, 2, 2, 0, 18'h0,     2'b01};
    vt[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 32'd1026, 32'h0,        32'h000055AD, 2, 2, 0, 18'h1,     2'b00};
    vt[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'd1025, 32'h0,        32'h0000BEEF, 2, 2, 0, 18'h0,     2'b00};
    vt[8]  = '{1'b0, 1'b1, 2'b01, 1'b1, 32'd1024, 32'h0,        32'hFFFFBEEF, 2, 2, 0, 18'h0,     2'b00};
    vt[9]  = '{1'b0, 1'b1, 2'b10, 1'b1, 32'd1026, 32'h0,        32'h55ADBEEF, 4, 4, 0, 18'h0,     2'b00};
    vt[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd1030, 32'h0000A1B2, 32'h55ADBEEF, 2, 0, 1, 18'h3,     2'b00};
    vt[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h12345678, 32'h00000000, 4, 0, 2, 18'h2,     2'b00};
    vt[12] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h0,        32'h12345678, 4, 4, 0, 18'h2,     2'b00};
    vt[13] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'd1024, 32'h0,        32'h55ADBEEF, 4, 4, 0, 18'h0,     2'b00};
    vt[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'd1020, 32'hCAFEF00D, 32'h55ADBEEF, 4, 0, 2, 18'h3FFFE, 2'b00};
    vt[15] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D, 4, 4, 0, 18'h3FFFE, 2'b00};

    for (int i = 0; i < 16; i++) begin
      do_access(vt[i].wr, vt[i].rd, vt[i].sz, vt[i].sgn, vt[i].addr, vt[i].data);
      chk($sformatf("v%0d_rdata", i), mon_rdata, vt[i].exp_rd);
      chk($sformatf("v%0d_ready_low", i), 32'(mon_lo), 32'(vt[i].exp_lo));
      chk($sformatf("v%0d_oe_low", i), 32'(mon_oe_lo), 32'(vt[i].exp_oe));
      chk($sformatf("v%0d_we_low", i), 32'(mon_we_lo), 32'(vt[i].exp_we));
      chk($sformatf("v%0d_addr0", i), 32'(mon_addr0), 32'(vt[i].exp_a0));
      chk($sformatf("v%0d_be_n0", i), 32'(mon_ben0), 32'(vt[i].exp_be0));
    end

    chk("sram0", 32'(sram[0]), 32'h0000BEEF);
    chk("sram1", 32'(sram[1]), 32'h000055AD);
    chk("sram2", 32'(sram[2]), 32'h00005678);
    chk("sram3", 32'(sram[3]), 32'h00001234);
    chk("sram_wrap_lo", 32'(sram[254]), 32'h0000F00D);
    chk("sram_wrap_hi", 32'(sram[255]), 32'h0000CAFE);

    // Reset during the second beat of a word load
    @(posedge clk); #1;
    rdEn = 1'b1; wrEn = 1'b0; size = 2'b10; loadSigned = 1'b0; address = 32'd1024;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_load_ce", 32'(ce_n), 32'd0);
    chk("mid_load_addr", 32'(sram_addr), 32'd1);
    rst = 1'b1; rdEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
    chk("post_rst_readdata", readData, 32'h0);
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h0);
    chk("post_rst_load", mon_rdata, 32'h55ADBEEF);
    chk("post_rst_ready_low", 32'(mon_lo), 32'd4);
    ref_last = mon_rdata;

    // Randomized accesses against the CPU-view reference memory
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'(1024 + 4 * w), d);
      ref_store(2'b10, 4 * w, d);
      chk($sformatf("init%0d_ready_low", w), 32'(mon_lo), 32'd4);
    end
    for (int t = 0; t < 200; t++) begin
      op  = $urandom_range(0, 2);
      sz  = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 63);
      sgn = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (op == 0) begin
        exp_rd   = ref_load(sz, off, sgn);
        ref_last = exp_rd;
      end else if (op == 2) begin
        exp_rd   = 32'h0;
        ref_last = exp_rd;
      end else begin
        exp_rd = ref_last;
      end
      do_access(op != 0, op != 1, sz, sgn, 32'(1024 + off), d);
      if (op != 0) ref_store(sz, off, d);
      chk($sformatf("rnd%0d_rdata op=%0d sz=%0d off=%0d", t, op, sz, off), mon_rdata, exp_rd);
      chk($sformatf("rnd%0d_ready_low", t), 32'(mon_lo), (nbytes(sz) == 4) ? 32'd4 : 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
